// File: rtl/dmi_pkg.sv
// Shared types for the DTM DMI controller:
// op codes, sticky status codes and FSM states.
package dmi_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2,
      OP_RSVD  = 2'd3
   } dmi_op_t;

   typedef enum logic [1:0] {
      STAT_SUCCESS = 2'd0,
      STAT_RSVD    = 2'd1,
      STAT_FAILED  = 2'd2,
      STAT_BUSY    = 2'd3
   } dmi_stat_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } dmi_state_t;

endpackage

// File: rtl/dtm_dmi_ctrl_if.sv
// DMI request/response bus between the DTM
// (master) and the Debug Module (slave).
interface dmi_if #(
   parameter int ABITS = 7,
   parameter int DBITS = 32
) ();

   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [ABITS-1:0] req_addr;
   logic [DBITS-1:0] req_data;
   logic             resp_valid;
   logic             resp_ready;
   logic [1:0]       resp_op;
   logic [DBITS-1:0] resp_data;

   modport master (
      output req_valid, req_op, req_addr, req_data,
      output resp_ready,
      input  req_ready, resp_valid, resp_op, resp_data
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_data,
      input  resp_ready,
      output req_ready, resp_valid, resp_op, resp_data
   );

endinterface

// File: rtl/dtm_dmi_ctrl_timeout_ctr.sv
// Saturating response-wait counter; expired is
// high on the TIMEOUT-th enabled cycle.
module dmi_timeout_ctr #(
   parameter int TIMEOUT = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic expired
);

   generate
      if (TIMEOUT > 0) begin : g_ctr
         localparam int CW = $clog2(TIMEOUT + 1);
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
         localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         // count enabled cycles, hold at MAX, clear wins
         always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
               cnt_d = '0;
            end else if (en && cnt_q != MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // counter register
         always_ff @(posedge clk) begin
            if (!reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign expired = en & (cnt_q >= LAST);
      end else begin : g_off
         logic unused_tie;
         assign unused_tie = ^{clk, reset, en, clr};
         assign expired    = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/dtm_dmi_ctrl.sv
// DTM controller: turns DMI Update-DR scans into
// DMI bus transactions and tracks sticky status.
module dtm_dmi_ctrl
   import dmi_pkg::*;
#(
   parameter int ABITS   = 7,
   parameter int DBITS   = 32,
   parameter int TIMEOUT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dmi_select,
   input  logic             update,
   input  logic             capture,
   input  logic [1:0]       dtm_op,
   input  logic [ABITS-1:0] dtm_addr,
   input  logic [DBITS-1:0] dtm_data,
   input  logic             dmireset,
   input  logic             dmihardreset,
   dmi_if.master            dmi,
   output logic [1:0]       cap_op,
   output logic [ABITS-1:0] cap_addr,
   output logic [DBITS-1:0] cap_data,
   output logic [1:0]       dmistat,
   output logic             busy
);

   dmi_state_t       state_q, state_d;
   dmi_stat_t        stat_q, stat_d;
   logic [1:0]       op_q, op_d;
   logic [ABITS-1:0] addr_q, addr_d;
   logic [DBITS-1:0] data_q, data_d;
   logic [DBITS-1:0] cdat_q, cdat_d;

   logic idle;
   logic in_resp;
   logic start;
   logic viol;
   logic expired;

   assign idle    = (state_q == ST_IDLE);
   assign in_resp = (state_q == ST_RESP);

   assign start = update & dmi_select & idle
                & (stat_q == STAT_SUCCESS)
                & ~dmireset & ~dmihardreset
                & (dtm_op == OP_READ | dtm_op == OP_WRITE);

   assign viol = dmi_select & (update | capture) & ~idle;

   dmi_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk     (clk),
      .reset   (reset),
      .en      (in_resp),
      .clr     (~in_resp),
      .expired (expired)
   );

   // next state, latched request and sticky status
   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      op_d    = op_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cdat_d  = cdat_q;

      if (dmireset) begin
         stat_d = STAT_SUCCESS;
      end
      if (viol && stat_d == STAT_SUCCESS) begin
         stat_d = STAT_BUSY;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_REQ;
               op_d    = dtm_op;
               addr_d  = dtm_addr;
               data_d  = dtm_data;
            end
         end
         ST_REQ: begin
            if (dmi.req_ready) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (dmi.resp_valid) begin
               state_d = ST_IDLE;
               if (op_q == OP_READ) begin
                  cdat_d = dmi.resp_data;
               end
               if (dmi.resp_op == STAT_FAILED) begin
                  stat_d = STAT_FAILED;
               end else if (dmi.resp_op == STAT_BUSY) begin
                  stat_d = STAT_BUSY;
               end
            end else if (expired) begin
               state_d = ST_IDLE;
               stat_d  = STAT_FAILED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (dmihardreset) begin
         state_d = ST_IDLE;
         stat_d  = STAT_SUCCESS;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         stat_q  <= STAT_SUCCESS;
         op_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         cdat_q  <= '0;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cdat_q  <= cdat_d;
      end
   end

   assign dmi.req_valid  = (state_q == ST_REQ);
   assign dmi.req_op     = op_q;
   assign dmi.req_addr   = addr_q;
   assign dmi.req_data   = data_q;
   assign dmi.resp_ready = in_resp;

   assign busy     = ~idle;
   assign dmistat  = stat_q;
   assign cap_op   = idle ? stat_q : STAT_BUSY;
   assign cap_addr = addr_q;
   assign cap_data = cdat_q;

endmodule

// File: tb/tb_dtm_dmi_ctrl.sv
// Bench for dtm_dmi_ctrl: directed scenarios then
// random transactions against a transaction model.
module tb_dtm_dmi_ctrl;
   import dmi_pkg::*;

   localparam int ABITS = 7;
   localparam int DBITS = 32;
   localparam int TO    = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             dmi_select = 1'b0;
   logic             update = 1'b0;
   logic             capture = 1'b0;
   logic [1:0]       dtm_op = '0;
   logic [ABITS-1:0] dtm_addr = '0;
   logic [DBITS-1:0] dtm_data = '0;
   logic             dmireset = 1'b0;
   logic             dmihardreset = 1'b0;
   logic [1:0]       cap_op;
   logic [ABITS-1:0] cap_addr;
   logic [DBITS-1:0] cap_data;
   logic [1:0]       dmistat;
   logic             busy;

   int n_chk = 0;
   int n_pass = 0;

   logic [1:0]  r_op, r_rop, m_stat;
   logic [6:0]  r_addr, m_addr;
   logic [31:0] r_data, r_rd, m_cap;
   int          r_rdly, r_sdly, n, exp_n;
   bit          r_sel, r_clr, issue;

   always #5 clk = ~clk;

   dmi_if #(.ABITS(ABITS), .DBITS(DBITS)) dmi ();

   dtm_dmi_ctrl #(
      .ABITS   (ABITS),
      .DBITS   (DBITS),
      .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .dmi_select   (dmi_select),
      .update       (update),
      .capture      (capture),
      .dtm_op       (dtm_op),
      .dtm_addr     (dtm_addr),
      .dtm_data     (dtm_data),
      .dmireset     (dmireset),
      .dmihardreset (dmihardreset),
      .dmi          (dmi),
      .cap_op       (cap_op),
      .cap_addr     (cap_addr),
      .cap_data     (cap_data),
      .dmistat      (dmistat),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit sel, input logic [1:0] op,
                       input logic [6:0] a, input logic [31:0] d);
      dmi_select = sel;
      update     = 1'b1;
      dtm_op     = op;
      dtm_addr   = a;
      dtm_data   = d;
      tick();
      update     = 1'b0;
   endtask

   // acts as the Debug Module until busy drops; n = busy cycles seen
   task automatic finish_txn(input int rdly, input int sdly,
                             input logic [1:0] rop,
                             input logic [31:0] rd, output int cyc);
      int rq = 0;
      int rs = 0;
      cyc = 0;
      while (busy && cyc < 64) begin
         cyc++;
         dmi.req_ready  = dmi.req_valid && (rq == rdly);
         dmi.resp_valid = dmi.resp_ready && (rs == sdly);
         dmi.resp_op    = rop;
         dmi.resp_data  = rd;
         if (dmi.req_valid) rq++;
         if (dmi.resp_ready) rs++;
         tick();
      end
      dmi.req_ready  = 1'b0;
      dmi.resp_valid = 1'b0;
      chk("txn_done", busy, 0);
   endtask

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   initial begin
      dmi.req_ready  = 1'b0;
      dmi.resp_valid = 1'b0;
      dmi.resp_op    = '0;
      dmi.resp_data  = '0;

      // reset state
      tick();
      tick();
      chk("rst_valid", dmi.req_valid, 0);
      chk("rst_rready", dmi.resp_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stat", dmistat, 0);
      chk("rst_capop", cap_op, 0);
      chk("rst_capdata", cap_data, 0);
      reset = 1'b1;
      tick();

      // fastest READ
      send(1, 2'd1, 7'h11, 32'h0);
      chk("rd_valid", dmi.req_valid, 1);
      chk("rd_op", dmi.req_op, 1);
      chk("rd_addr", dmi.req_addr, 7'h11);
      finish_txn(0, 0, 2'd0, 32'hDEADBEEF, n);
      chk("rd_busy_n", n, 2);
      chk("rd_capdata", cap_data, 32'hDEADBEEF);
      chk("rd_capop", cap_op, 0);
      chk("rd_capaddr", cap_addr, 7'h11);

      // WRITE failing, blocked READ, dmireset, READ again
      send(1, 2'd2, 7'h22, 32'h12345678);
      chk("wr_data", dmi.req_data, 32'h12345678);
      finish_txn(0, 1, 2'd2, 32'hAAAA5555, n);
      chk("wr_busy_n", n, 3);
      chk("wr_stat", dmistat, 2);
      chk("wr_capop", cap_op, 2);
      chk("wr_capdata", cap_data, 32'hDEADBEEF);
      send(1, 2'd1, 7'h33, 32'h0);
      chk("blk_valid", dmi.req_valid, 0);
      chk("blk_busy", busy, 0);
      tick();
      chk("blk_valid2", dmi.req_valid, 0);
      chk("blk_addr", cap_addr, 7'h22);
      dmireset = 1'b1;
      tick();
      dmireset = 1'b0;
      chk("clr_stat", dmistat, 0);
      send(1, 2'd1, 7'h33, 32'h0);
      chk("rd2_valid", dmi.req_valid, 1);
      finish_txn(1, 0, 2'd0, 32'h0BADF00D, n);
      chk("rd2_busy_n", n, 3);
      chk("rd2_capdata", cap_data, 32'h0BADF00D);

      // update during RESP
      send(1, 2'd1, 7'h44, 32'h0);
      dmi.req_ready = 1'b1;
      tick();
      dmi.req_ready = 1'b0;
      chk("ov_rready", dmi.resp_ready, 1);
      dtm_addr = 7'h55;
      update   = 1'b1;
      tick();
      update   = 1'b0;
      chk("ov_stat", dmistat, 3);
      chk("ov_capop", cap_op, 3);
      chk("ov_busy", busy, 1);
      chk("ov_addr", cap_addr, 7'h44);
      dmi.resp_valid = 1'b1;
      dmi.resp_op    = 2'd0;
      dmi.resp_data  = 32'h11112222;
      tick();
      dmi.resp_valid = 1'b0;
      chk("ov_done", busy, 0);
      chk("ov_capop2", cap_op, 3);
      chk("ov_stat2", dmistat, 3);
      chk("ov_capdata", cap_data, 32'h11112222);
      dmireset = 1'b1;
      tick();
      dmireset = 1'b0;
      chk("ov_clr", cap_op, 0);

      // capture during REQ, error beats same-cycle dmireset
      send(1, 2'd2, 7'h45, 32'h1);
      capture = 1'b1;
      tick();
      chk("cap_stat", dmistat, 3);
      dmireset = 1'b1;
      tick();
      chk("cap_rst_err", dmistat, 3);
      capture = 1'b0;
      tick();
      dmireset = 1'b0;
      chk("cap_rst", dmistat, 0);
      chk("cap_capop", cap_op, 3);
      finish_txn(0, 0, 2'd0, 32'h0, n);
      chk("cap_busy_n", n, 2);
      chk("cap_capdata", cap_data, 32'h11112222);

      // timeout, then response on the last cycle
      send(1, 2'd1, 7'h66, 32'h0);
      finish_txn(0, 10, 2'd0, 32'h99999999, n);
      chk("to_busy_n", n, 1 + TO);
      chk("to_stat", dmistat, 2);
      chk("to_capdata", cap_data, 32'h11112222);
      dmireset = 1'b1;
      tick();
      dmireset = 1'b0;
      send(1, 2'd1, 7'h66, 32'h0);
      finish_txn(0, TO - 1, 2'd0, 32'hCAFE0001, n);
      chk("lt_busy_n", n, 1 + TO);
      chk("lt_stat", dmistat, 0);
      chk("lt_capdata", cap_data, 32'hCAFE0001);

      // hard reset during REQ with a same-cycle update
      send(1, 2'd1, 7'h70, 32'h0);
      dmihardreset = 1'b1;
      update       = 1'b1;
      dtm_op       = 2'd2;
      tick();
      dmihardreset = 1'b0;
      update       = 1'b0;
      chk("hr_valid", dmi.req_valid, 0);
      chk("hr_busy", busy, 0);
      chk("hr_stat", dmistat, 0);
      tick();
      chk("hr_busy2", busy, 0);

      // reset mid-RESP, full-width fields
      send(1, 2'd2, 7'h7F, 32'hFFFFFFFF);
      chk("fw_addr", dmi.req_addr, 7'h7F);
      chk("fw_data", dmi.req_data, 32'hFFFFFFFF);
      dmi.req_ready = 1'b1;
      tick();
      dmi.req_ready = 1'b0;
      chk("mr_rready", dmi.resp_ready, 1);
      reset = 1'b0;
      tick();
      chk("mr_out", {dmi.req_valid, dmi.resp_ready, dmi.req_op,
                     dmi.req_addr, cap_op, cap_addr, dmistat, busy}, 0);
      chk("mr_wide", {dmi.req_data, cap_data}, 0);
      reset = 1'b1;
      tick();
      send(1, 2'd1, 7'h7F, 32'h0);
      finish_txn(0, 0, 2'd0, 32'hFFFFFFFF, n);
      chk("fw_capdata", cap_data, 32'hFFFFFFFF);
      chk("fw_capaddr", cap_addr, 7'h7F);

      // random transactions against a transaction-level model
      m_stat = 2'd0;
      m_cap  = 32'hFFFFFFFF;
      m_addr = 7'h7F;
      for (int i = 0; i < 40; i++) begin
         r_op   = 2'($urandom_range(3, 0));
         r_addr = 7'($urandom);
         r_data = $urandom;
         r_rd   = $urandom;
         case ($urandom_range(3, 0))
            0, 1:    r_rop = 2'd0;
            2:       r_rop = 2'd2;
            default: r_rop = 2'd3;
         endcase
         r_rdly = $urandom_range(2, 0);
         r_sdly = $urandom_range(5, 0);
         r_sel  = ($urandom_range(4, 0) != 0);
         r_clr  = ($urandom_range(5, 0) == 0);
         if (m_stat != 0 && $urandom_range(1, 0) == 1) begin
            dmireset = 1'b1;
            tick();
            dmireset = 1'b0;
            m_stat   = 2'd0;
         end
         dmireset = r_clr;
         send(r_sel, r_op, r_addr, r_data);
         dmireset = 1'b0;
         if (r_clr) m_stat = 2'd0;
         issue = r_sel && !r_clr && m_stat == 0
               && (r_op == 2'd1 || r_op == 2'd2);
         chk("rnd_valid", dmi.req_valid, issue);
         if (issue) begin
            m_addr = r_addr;
            chk("rnd_req", {dmi.req_op, dmi.req_addr, dmi.req_data},
                {r_op, r_addr, r_data});
            finish_txn(r_rdly, r_sdly, r_rop, r_rd, n);
            exp_n = r_rdly + 1 + min2(r_sdly + 1, TO);
            chk("rnd_busy_n", n, exp_n);
            if (r_sdly + 1 > TO) begin
               m_stat = 2'd2;
            end else begin
               if (r_rop == 2'd2) m_stat = 2'd2;
               if (r_rop == 2'd3) m_stat = 2'd3;
               if (r_op == 2'd1) m_cap = r_rd;
            end
         end
         chk("rnd_stat", dmistat, m_stat);
         chk("rnd_capop", cap_op, m_stat);
         chk("rnd_capdata", cap_data, m_cap);
         chk("rnd_capaddr", cap_addr, m_addr);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
